// File: rtl/l2_sched_pkg.sv
// Shared types and constants for the L2 cache scheduler.
// Holds the scheduler state encoding, L2 geometry constants and the
// burst-length offset helper (a 4-bit length field encodes len+1 words).
package l2_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_L1_XFER  = 2'd1,
        ST_DDR_REQ  = 2'd2,
        ST_DDR_FILL = 2'd3
    } sched_state_t;

    localparam logic [11:0] L2_FULL_WORDS   = 12'hFFF;
    localparam int unsigned WORDS_PER_BEAT  = 8;
    localparam int unsigned BEAT_WORD_SHIFT = 3;

    localparam int unsigned LEN_W      = 4;
    localparam int unsigned WORD_CNT_W = LEN_W + 1;
    localparam int unsigned WDOG_CNT_W = 16;

    // Number of words a length field stands for (field holds words-1).
    function automatic logic [WORD_CNT_W-1:0] burst_words(input logic [LEN_W-1:0] len);
        return WORD_CNT_W'(len) + WORD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/l2_sched_watchdog.sv
// DDR acknowledge/beat watchdog for the L2 scheduler.
// Counts consecutive cycles with count_en high; any cycle with count_en low
// clears the count. timeout_c rises combinationally on the cycle that
// completes TIMEOUT_CYCLES consecutive counted cycles.
// Ports: clk_166M66, mcu_sys_rst_n (async active-low), count_en, timeout_c.
module l2_sched_watchdog
    import l2_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_166M66,
    input  logic mcu_sys_rst_n,
    input  logic count_en,
    output logic timeout_c
);

    localparam logic [WDOG_CNT_W-1:0] LIMIT = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_CNT_W-1:0] cnt;

    assign timeout_c = count_en && (cnt == LIMIT);

    // Restart after a timeout so a later DDR_REQ gets a full window.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            cnt <= '0;
        end else if (!count_en || timeout_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WDOG_CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2_cache_sched.sv
// L2 cache scheduler: arbitrates the dual-port L2 between L1 read bursts
// (port A, 16-bit) and DDR refill bursts (port B, 128-bit), and holds off
// either port while the L2 reports an L1/DDR address conflict.
// Ports: clk_166M66, mcu_sys_rst_n; L2 status i_l2_unread_size,
// i_l1ddr_rw_conflicts; L1 handshake i_l1_req/i_l1_req_len/o_l1_grant/
// o_l1_done; DDR handshake o_ddr_req/i_ddr_ack/i_ddr_beat_valid/o_fill_done;
// L2 strobes o_l2_l1_operate_enable/o_l2_l1_rw/o_l2_ddr_operate_enable/
// o_l2_ddr_rw; status o_busy, o_err.
// The port enables are combinational (they qualify same-cycle data); all
// other outputs are registered.
// Optional DDR watchdog: define L2_SCHED_DDR_TIMEOUT_EN.
module l2_cache_sched
    import l2_sched_pkg::*;
#(
    parameter int unsigned FILL_BEATS     = 8,
    parameter logic [11:0] LOW_WATERMARK  = 12'd512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_166M66,
    input  logic             mcu_sys_rst_n,
    input  logic [11:0]      i_l2_unread_size,
    input  logic             i_l1ddr_rw_conflicts,
    input  logic             i_l1_req,
    input  logic [LEN_W-1:0] i_l1_req_len,
    output logic             o_l1_grant,
    output logic             o_l1_done,
    output logic             o_l2_l1_operate_enable,
    output logic             o_l2_l1_rw,
    output logic             o_ddr_req,
    input  logic             i_ddr_ack,
    input  logic             i_ddr_beat_valid,
    output logic             o_l2_ddr_operate_enable,
    output logic             o_l2_ddr_rw,
    output logic             o_fill_done,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned         BEAT_CNT_W = 7;
    localparam logic [12:0]         FILL_WORDS = 13'(FILL_BEATS * WORDS_PER_BEAT);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FILL_BEATS - 1);

    // Elaboration-time guard on the parameter ranges the counters are sized for.
    if (FILL_BEATS < 1 || FILL_BEATS > 64 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536 ||
        WORDS_PER_BEAT != (1 << BEAT_WORD_SHIFT)) begin : g_param_check
        $error("l2_cache_sched: illegal parameterisation");
    end

    sched_state_t           state, state_nxt;
    logic [WORD_CNT_W-1:0]  word_cnt, word_cnt_nxt;
    logic [LEN_W-1:0]       len_q, len_nxt;
    logic [BEAT_CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic                   grant_nxt, l1_done_nxt, fill_done_nxt;

    logic [11:0] free_words;
    logic        l1_fits, fill_wanted, words_done;
    logic        a_en_c, b_en_c, timeout_c;

    assign free_words  = L2_FULL_WORDS - i_l2_unread_size;
    assign l1_fits     = i_l2_unread_size >= 12'(burst_words(i_l1_req_len));
    assign fill_wanted = (i_l2_unread_size <= LOW_WATERMARK) && ({1'b0, free_words} >= FILL_WORDS);
    assign words_done  = word_cnt == burst_words(len_q);

    // Port strobes: conflict gates both; port A stops once the burst is complete.
    assign a_en_c = (state == ST_L1_XFER) && !words_done && !i_l1ddr_rw_conflicts;
    assign b_en_c = (state == ST_DDR_FILL) && i_ddr_beat_valid && !i_l1ddr_rw_conflicts;

    assign o_l2_l1_operate_enable  = a_en_c;
    assign o_l2_ddr_operate_enable = b_en_c;
    assign o_l2_l1_rw              = 1'b0;

`ifdef L2_SCHED_DDR_TIMEOUT_EN
    logic wdog_count_en;
    logic err_q;

    assign wdog_count_en = ((state == ST_DDR_REQ) && !i_ddr_ack) ||
                           ((state == ST_DDR_FILL) && !b_en_c);

    l2_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_166M66    (clk_166M66),
        .mcu_sys_rst_n (mcu_sys_rst_n),
        .count_en      (wdog_count_en),
        .timeout_c     (timeout_c)
    );

    // Sticky error until reset.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_c) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign timeout_c = 1'b0;
    assign o_err     = 1'b0;
`endif

    // Next-state, counter and pulse logic.
    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        len_nxt       = len_q;
        beat_cnt_nxt  = beat_cnt;
        grant_nxt     = 1'b0;
        l1_done_nxt   = 1'b0;
        fill_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                // L1 wins unless it lacks data; a starved L1 falls through to the fill check.
                if (i_l1_req && l1_fits && !i_l1ddr_rw_conflicts) begin
                    state_nxt    = ST_L1_XFER;
                    grant_nxt    = 1'b1;
                    len_nxt      = i_l1_req_len;
                    word_cnt_nxt = '0;
                end else if (fill_wanted) begin
                    state_nxt = ST_DDR_REQ;
                end
            end
            ST_L1_XFER: begin
                if (words_done) begin
                    state_nxt   = ST_IDLE;
                    l1_done_nxt = 1'b1;
                end else if (a_en_c) begin
                    word_cnt_nxt = word_cnt + WORD_CNT_W'(1);
                end
            end
            ST_DDR_REQ: begin
                if (timeout_c) begin
                    state_nxt = ST_IDLE;
                end else if (i_ddr_ack) begin
                    state_nxt    = ST_DDR_FILL;
                    beat_cnt_nxt = '0;
                end
            end
            ST_DDR_FILL: begin
                if (timeout_c) begin
                    state_nxt = ST_IDLE;
                end else if (b_en_c) begin
                    beat_cnt_nxt = beat_cnt + BEAT_CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt     = ST_IDLE;
                        fill_done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            o_l1_grant  <= 1'b0;
            o_l1_done   <= 1'b0;
            o_fill_done <= 1'b0;
            o_ddr_req   <= 1'b0;
            o_l2_ddr_rw <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_cnt    <= word_cnt_nxt;
            len_q       <= len_nxt;
            beat_cnt    <= beat_cnt_nxt;
            o_l1_grant  <= grant_nxt;
            o_l1_done   <= l1_done_nxt;
            o_fill_done <= fill_done_nxt;
            o_ddr_req   <= state_nxt == ST_DDR_REQ;
            o_l2_ddr_rw <= state_nxt == ST_DDR_FILL;
            o_busy      <= state_nxt != ST_IDLE;
        end
    end

endmodule

// File: doc/l2_cache_sched.md
Name: l2_cache_sched

Overview:
- Scheduler for the dual-port L2 cache (16-bit L1 port, 128-bit DDR port) in the MCU memory path.
- Decides each cycle whether the L2 is idle, refilled from DDR (fill bursts) or drained to L1 (read bursts).
- Drives the L2's per-port operate_enable/rw strobes and stalls L1 transfers while the L2 reports an L1/DDR address conflict.
- Sits between the L1 cache miss logic, the DDR controller and the L2 cache instance.

Parameters:
- FILL_BEATS, 8: 128-bit DDR beats per fill burst (1..64). One beat is 8 L1 words.
- LOW_WATERMARK, 12'd512: fill is requested when unread words are at or below this value.
- TIMEOUT_CYCLES, 1024: DDR ack watchdog limit. Used only with the optional feature.

Ports:
- clk_166M66  in  1  system clock
- mcu_sys_rst_n  in  1  asynchronous active-low reset
- i_l2_unread_size  in  12  unread 16-bit words held in L2 (0 = empty, 12'hFFF = full)
- i_l1ddr_rw_conflicts  in  1  L2 reports that the L1 and DDR operating addresses collide
- i_l1_req  in  1  L1 requests a read burst; held high until o_l1_grant
- i_l1_req_len  in  4  burst length minus 1 (1..16 words); sampled at grant
- o_l1_grant  out  1  one-cycle pulse: request accepted
- o_l1_done  out  1  one-cycle pulse: last word transferred
- o_l2_l1_operate_enable  out  1  L2 port A enable
- o_l2_l1_rw  out  1  L2 port A direction; always 0 (L2->L1 read)
- o_ddr_req  out  1  fill request to the DDR controller
- i_ddr_ack  in  1  DDR accepted the fill request
- i_ddr_beat_valid  in  1  a 128-bit beat is on the DDR data bus this cycle
- o_l2_ddr_operate_enable  out  1  L2 port B enable
- o_l2_ddr_rw  out  1  L2 port B direction; 1 during fill (DDR->L2)
- o_fill_done  out  1  one-cycle pulse after the last fill beat
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky watchdog error (optional feature only; otherwise tied 0)

Behaviour:
- Reset: state IDLE; all counters 0; every output 0. A reset mid-burst aborts the burst with no done pulse.
- Definitions:
  - free = 12'hFFF - i_l2_unread_size, 12-bit.
  - fill_words = FILL_BEATS*8. The product is widened to 13 bits before comparison.
- States: IDLE, L1_XFER, DDR_REQ, DDR_FILL.
- IDLE priority, evaluated each cycle:
  1. If i_l1_req and unread >= len+1 and no conflict: go to L1_XFER. Pulse o_l1_grant, latch len, clear the word counter.
  2. Else if unread <= LOW_WATERMARK and free >= fill_words: go to DDR_REQ.
  3. Else stay in IDLE.
  4. An L1 request that cannot be served because unread < len+1 forces the fill check, so fill wins.
- L1_XFER:
  - o_l2_l1_operate_enable = !i_l1ddr_rw_conflicts. The counter increments only on enabled cycles.
  - After len+1 enabled cycles, go to IDLE on the next edge with o_l1_done high for that one cycle.
  - Minimum latency from grant to done is len+2 cycles.
- DDR_REQ:
  - o_ddr_req held high until i_ddr_ack is sampled high, then go to DDR_FILL.
  - Ack and req high in the same cycle counts as acceptance.
- DDR_FILL:
  - o_l2_ddr_operate_enable = i_ddr_beat_valid && !i_l1ddr_rw_conflicts; o_l2_ddr_rw = 1.
  - A beat arriving during a conflict is not written. The DDR controller must hold beat_valid until it is accepted.
  - After FILL_BEATS accepted beats, pulse o_fill_done and go to IDLE.
- Exclusivity: port A and port B enables are never high in the same cycle.
- i_l1_req_len changes after grant are ignored. i_l1_req dropping before grant is legal (no grant is issued).

Optional Feature:
- Macro L2_SCHED_DDR_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in DDR_REQ and in DDR_FILL without an accepted beat.
  - On reaching TIMEOUT_CYCLES: drop o_ddr_req, go to IDLE, set o_err (sticky until reset). No o_fill_done is pulsed.
  - The counter clears on ack, on each accepted beat, and on leaving those states.
- When undefined: no counter exists, o_err is tied 0, and the block waits indefinitely.

Decomposition:
- Package l2_sched_pkg holds:
  - the state enumeration (2-bit);
  - L2_FULL_WORDS = 12'hFFF;
  - WORDS_PER_BEAT = 8 and the beat-to-word shift of 3;
  - the 4-bit length-offset convention.
- Sub-module l2_sched_watchdog holds the timeout counter. It is instantiated only under the macro.

Test Plan:
- Reset mid-L1_XFER (len=15, after 5 words) -> all outputs 0 within the same cycle; state IDLE; no o_l1_done.
- unread=100, i_l1_req with len=3 -> grant in cycle 1, enable high 4 cycles, o_l1_done in cycle 6, no DDR request.
- unread=400 (<=512), free=3695, no L1 request -> o_ddr_req; ack after 3 cycles; 8 beats with a 1-cycle gap -> 8 port-B enables, then o_fill_done.
- unread=2, i_l1_req len=7 -> no grant; fill runs first; after unread is raised to 66, grant issues.
- Conflict high for 3 cycles during a 4-word L1 burst -> enable low for those 3 cycles; done is delayed by 3 cycles; exactly 4 enabled cycles.
- With the macro defined and TIMEOUT_CYCLES=16, ack never arrives -> o_ddr_req drops after 16 cycles, o_err=1 until reset, state IDLE.
